// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath blocks.
//   - ALU selector encodings consumed by the ALU and carried through ID/EX.
//   - Forward-select codes produced by fwd_unit.
//   - REG_ZERO: index of the hard-wired zero register, which is never forwarded.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd10;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding match logic for a single source register index.
// Ports:
//   src             in  REG_W  source register index held in EX
//   exmem_regwrite  in  1      EX/MEM stage will write a register
//   exmem_rd        in  REG_W  EX/MEM destination index
//   memwb_regwrite  in  1      MEM/WB stage will write a register
//   memwb_rd        in  REG_W  MEM/WB destination index
//   sel             out 2      FWD_EXMEM / FWD_MEMWB / FWD_RF
module fwd_unit
  import mips_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic             exmem_regwrite,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             memwb_regwrite,
  input  logic [REG_W-1:0] memwb_rd,
  output fwd_sel_e         sel
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  // $0 never matches, so writes aimed at it can never leak into an operand.
  assign w_exmem_hit = exmem_regwrite && (exmem_rd != REG_W'(REG_ZERO)) && (exmem_rd == src);
  assign w_memwb_hit = memwb_regwrite && (memwb_rd != REG_W'(REG_ZERO)) && (memwb_rd == src);

  // The younger result (EX/MEM) wins when both stages target the same register.
  always_comb begin
    sel = FWD_RF;
    if (w_exmem_hit)      sel = FWD_EXMEM;
    else if (w_memwb_hit) sel = FWD_MEMWB;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use hazard detection.
// Ports (see mips_pkg for encodings):
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_*                       decoded operands, indices and control from decode
//   flush                      kill the instruction entering EX (inserts a bubble)
//   exmem_regwrite/rd/result   EX/MEM write-back candidate for forwarding
//   memwb_regwrite/rd/result   MEM/WB write-back candidate for forwarding
//   stall                      comb load-use hold for PC and IF/ID
//   ex_valid, ex_rd, ex_*      registered EX instruction fields
//   ex_data1/ex_data2          ALU operands after forwarding / immediate select
//   ex_selector                ALU selector
//   ex_store_data              forwarded rt, used as store data
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rt,
  input  logic [SEL_W-1:0]  id_alu_sel,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              flush,
  input  logic              exmem_regwrite,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [SEL_W-1:0]  ex_selector,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg
);

  logic              r_valid;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_rd;
  logic [SEL_W-1:0]  r_alu_sel;
  logic              r_alusrc;
  logic              r_regwrite;
  logic              r_memread;
  logic              r_memwrite;
  logic              r_memtoreg;

  logic              w_bubble;
  logic              w_ctrl_en;
  fwd_sel_e          w_sel_rs;
  fwd_sel_e          w_sel_rt;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // Load-use: the load's data is not available until MEM/WB, so a dependent
  // instruction in decode must wait one cycle. r_valid gates out bubbles.
  assign stall = r_valid && r_memread && (r_rd != REG_W'(REG_ZERO)) && id_valid &&
                 ((r_rd == id_rs) || (id_uses_rt && (r_rd == id_rt)));

  // Flush and stall both insert a bubble; stall still holds upstream even when flushing.
  assign w_bubble  = flush || stall;
  assign w_ctrl_en = !w_bubble && id_valid;

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_alu_sel  <= SEL_W'(ALU_AND);
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
    end else begin
      // Data fields are don't-care in a bubble, so they load unconditionally.
      r_rs_data  <= id_rs_data;
      r_rt_data  <= id_rt_data;
      r_imm      <= id_imm;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rd       <= id_rd;
      r_alu_sel  <= id_alu_sel;
      r_alusrc   <= id_alusrc;
      r_valid    <= w_ctrl_en;
      r_regwrite <= w_ctrl_en && id_regwrite;
      r_memread  <= w_ctrl_en && id_memread;
      r_memwrite <= w_ctrl_en && id_memwrite;
      r_memtoreg <= w_ctrl_en && id_memtoreg;
    end
  end

  // ---- EX operand selection (comb) ----
  fwd_unit #(.REG_W(REG_W)) u_fwd_rs (
    .src            (r_rs),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .sel            (w_sel_rs)
  );

  fwd_unit #(.REG_W(REG_W)) u_fwd_rt (
    .src            (r_rt),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .sel            (w_sel_rt)
  );

  always_comb begin
    w_fwd_rs = r_rs_data;
    case (w_sel_rs)
      FWD_EXMEM: w_fwd_rs = exmem_result;
      FWD_MEMWB: w_fwd_rs = memwb_result;
      default:   w_fwd_rs = r_rs_data;
    endcase
  end

  always_comb begin
    w_fwd_rt = r_rt_data;
    case (w_sel_rt)
      FWD_EXMEM: w_fwd_rt = exmem_result;
      FWD_MEMWB: w_fwd_rt = memwb_result;
      default:   w_fwd_rt = r_rt_data;
    endcase
  end

  assign ex_valid      = r_valid;
  assign ex_data1      = w_fwd_rs;
  assign ex_data2      = r_alusrc ? r_imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign ex_selector   = r_alu_sel;
  assign ex_rd         = r_rd;
  assign ex_regwrite   = r_regwrite;
  assign ex_memread    = r_memread;
  assign ex_memwrite   = r_memwrite;
  assign ex_memtoreg   = r_memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic [3:0]  id_alu_sel;
  logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        flush;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        stall, ex_valid;
  logic [31:0] ex_data1, ex_data2, ex_store_data;
  logic [3:0]  ex_selector;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_W(5), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_alu_sel(id_alu_sel), .id_alusrc(id_alusrc),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .ex_valid(ex_valid), .ex_data1(ex_data1), .ex_data2(ex_data2),
    .ex_selector(ex_selector), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_idle();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0; id_alu_sel = ALU_AND;
    id_alusrc = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
  endtask

  task automatic fwd_idle();
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  // R-type: rd <- rs op rt
  task automatic id_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [3:0] sel);
    id_idle();
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_uses_rt = 1; id_alu_sel = sel; id_regwrite = 1;
  endtask

  // lw rd, imm(rs)
  task automatic id_lw(input logic [4:0] rs, input logic [4:0] rd, input logic [31:0] rsd);
    id_idle();
    id_valid = 1; id_rs = rs; id_rt = rd; id_rd = rd; id_rs_data = rsd; id_imm = 32'd4;
    id_alu_sel = ALU_ADD; id_alusrc = 1; id_regwrite = 1; id_memread = 1; id_memtoreg = 1;
  endtask

  initial begin
    rst_n = 0; flush = 0;
    id_idle(); fwd_idle();
    #12;
    chk("rst_valid", {31'd0, ex_valid}, 0);
    chk("rst_sel", {28'd0, ex_selector}, {28'd0, ALU_AND});
    chk("rst_ctrl", {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}, 0);
    chk("rst_data1", ex_data1, 0);
    tick();
    rst_n = 1;

    // Async reset mid-run, no clock edge involved.
    id_lw(5'd1, 5'd2, 32'h40);
    tick();
    chk("pre_rst_valid", {31'd0, ex_valid}, 1);
    chk("pre_rst_memread", {31'd0, ex_memread}, 1);
    id_idle();
    #3 rst_n = 0;
    #1;
    chk("async_rst_valid", {31'd0, ex_valid}, 0);
    chk("async_rst_ctrl", {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}, 0);
    tick();
    rst_n = 1;

    // add $3,$1,$2 then sub $4,$3,$1 with EX/MEM forwarding of $3.
    id_rtype(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, ALU_ADD);
    tick();
    chk("add_data1", ex_data1, 32'h1);
    chk("add_data2", ex_data2, 32'h2);
    chk("add_sel", {28'd0, ex_selector}, {28'd0, ALU_ADD});
    chk("add_rd", {27'd0, ex_rd}, 32'd3);
    id_rtype(5'd3, 5'd1, 5'd4, 32'h99, 32'h1, ALU_SUB);
    exmem_regwrite = 1; exmem_rd = 5'd3; exmem_result = 32'h10;
    tick();
    chk("sub_fwd_data1", ex_data1, 32'h10);
    chk("sub_data2", ex_data2, 32'h1);
    chk("sub_sel", {28'd0, ex_selector}, {28'd0, ALU_SUB});

    // Double match: EX/MEM wins; MEM/WB used once EX/MEM drops.
    id_rtype(5'd5, 5'd6, 5'd7, 32'h55, 32'h66, ALU_OR);
    exmem_regwrite = 1; exmem_rd = 5'd5; exmem_result = 32'hA;
    memwb_regwrite = 1; memwb_rd = 5'd5; memwb_result = 32'hB;
    tick();
    chk("dbl_exmem_wins", ex_data1, 32'hA);
    chk("dbl_rt_rf", ex_data2, 32'h66);
    exmem_regwrite = 0;
    #1;
    chk("memwb_only", ex_data1, 32'hB);
    memwb_rd = 5'd6;
    #1;
    chk("memwb_rt_fwd", ex_data2, 32'hB);
    chk("memwb_rt_store", ex_store_data, 32'hB);
    fwd_idle();

    // Load-use: lw $7 then add $8,$7,$0.
    id_lw(5'd1, 5'd7, 32'h100);
    tick();
    chk("lw_memread", {31'd0, ex_memread}, 1);
    id_rtype(5'd7, 5'd0, 5'd8, 32'h0, 32'h0, ALU_ADD);
    #1;
    chk("lu_stall", {31'd0, stall}, 1);
    tick();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 0);
    chk("lu_bubble_regwrite", {31'd0, ex_regwrite}, 0);
    chk("lu_stall_once", {31'd0, stall}, 0);
    memwb_regwrite = 1; memwb_rd = 5'd7; memwb_result = 32'h77;
    tick();
    chk("lu_add_valid", {31'd0, ex_valid}, 1);
    chk("lu_add_data1", ex_data1, 32'h77);
    chk("lu_add_data2", ex_data2, 32'h0);
    fwd_idle();

    // A bubble carrying memread must not stall a dependent instruction.
    id_lw(5'd1, 5'd7, 32'h100);
    id_valid = 0;
    tick();
    chk("inv_ctrl_zero", {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}, 0);
    id_rtype(5'd7, 5'd7, 5'd8, 32'h0, 32'h0, ALU_ADD);
    #1;
    chk("bubble_no_stall", {31'd0, stall}, 0);

    // Flush without stall.
    id_rtype(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, ALU_ADD);
    id_memwrite = 1;
    flush = 1;
    tick();
    chk("fl_valid", {31'd0, ex_valid}, 0);
    chk("fl_regwrite", {31'd0, ex_regwrite}, 0);
    chk("fl_memwrite", {31'd0, ex_memwrite}, 0);
    flush = 0;

    // Flush while a load-use stall is active.
    id_lw(5'd1, 5'd7, 32'h100);
    tick();
    id_rtype(5'd2, 5'd7, 5'd8, 32'h0, 32'h0, ALU_ADD);
    id_memwrite = 1;
    flush = 1;
    #1;
    chk("fl_st_stall", {31'd0, stall}, 1);
    tick();
    chk("fl_st_valid", {31'd0, ex_valid}, 0);
    chk("fl_st_regwrite", {31'd0, ex_regwrite}, 0);
    chk("fl_st_memwrite", {31'd0, ex_memwrite}, 0);
    flush = 0;

    // addi $9,$0,-1: $0 is never forwarded even though MEM/WB targets it.
    id_idle();
    id_valid = 1; id_rs = 5'd0; id_rt = 5'd9; id_rd = 5'd9; id_rs_data = 32'h1234;
    id_rt_data = 32'h5678; id_imm = 32'hFFFF_FFFF; id_alusrc = 1; id_regwrite = 1;
    id_alu_sel = ALU_ADD;
    memwb_regwrite = 1; memwb_rd = 5'd0; memwb_result = 32'hDEAD;
    tick();
    chk("addi_data2", ex_data2, 32'hFFFF_FFFF);
    chk("addi_no_r0_fwd", ex_data1, 32'h1234);
    chk("addi_store", ex_store_data, 32'h5678);
    chk("addi_rd", {27'd0, ex_rd}, 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
